rr_arbiter_4: RTL and testbench



---
 rtl/rr_arbiter_4.sv | 105 ++++++++++
 tb/tb_rr_arbiter_4.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a per-grant hold limit.
// One IDLE cycle always separates two grants, so ownership never changes back-to-back.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic             done,
    output logic [3:0]       gnt,
    output logic [1:0]       gnt_idx,
    output logic             gnt_valid,
    output logic [CNT_W-1:0] hold_cnt,
    output logic             dbg_state,
    output logic [1:0]       dbg_ptr
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    function automatic logic [3:0] decode_2to4(input logic [1:0] sel);
        logic [3:0] onehot;
        onehot = 4'b0000;
        onehot[sel] = 1'b1;
        return onehot;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pick;
    logic [1:0]       cand;
    logic             found;
    logic             release_now;

    // Rotating search: the first requester at or after the pointer wins.
    always_comb begin
        pick  = ptr_q;
        cand  = ptr_q;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign release_now = done || !req[idx_q] || (cnt_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d   = pick;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d   = idx_q + 2'd1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_valid = (state_q == GRANT);
    assign gnt       = gnt_valid ? decode_2to4(idx_q) : 4'b0000;
    assign gnt_idx   = idx_q;
    assign hold_cnt  = cnt_q;
    assign dbg_state = state_q;
    assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: inputs change on the falling edge, outputs
// are checked on the falling edge, i.e. half a cycle after each rising edge.
module tb_rr_arbiter_4;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 8;

    logic             clk;
    logic             rst;
    logic [3:0]       req;
    logic             done;
    logic [3:0]       gnt;
    logic [1:0]       gnt_idx;
    logic             gnt_valid;
    logic [CNT_W-1:0] hold_cnt;
    logic             dbg_state;
    logic [1:0]       dbg_ptr;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .hold_cnt  (hold_cnt),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Invariants checked every cycle once reset has been applied.
    logic inv_en = 1'b0;
    always @(negedge clk) begin
        if (inv_en) begin
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (!gnt_valid) check("gnt_zero_idle", 32'(gnt), 32'd0);
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   32'(gnt),       32'd0);
        check({tag, "_valid"}, 32'(gnt_valid), 32'd0);
        check({tag, "_idx"},   32'(gnt_idx),   32'd0);
        check({tag, "_hold"},  32'(hold_cnt),  32'd0);
        check({tag, "_ptr"},   32'(dbg_ptr),   32'd0);
    endtask

    initial begin
        rst  = 1'b0;
        req  = 4'b0000;
        done = 1'b0;
        @(negedge clk);

        // 1. Reset then single request
        do_reset(2);
        inv_en = 1'b1;
        check_reset_outputs("t1_rst");
        req = 4'b0100;
        step();
        check("t1_gnt", 32'(gnt), 32'h4);
        check("t1_idx", 32'(gnt_idx), 32'd2);
        check("t1_hold0", 32'(hold_cnt), 32'd0);
        step();
        check("t1_hold1", 32'(hold_cnt), 32'd1);
        step();
        check("t1_hold2", 32'(hold_cnt), 32'd2);
        done = 1'b1;
        req  = 4'b0000;
        step();
        done = 1'b0;
        check("t1_rel_valid", 32'(gnt_valid), 32'd0);
        check("t1_rel_gnt", 32'(gnt), 32'd0);
        check("t1_rel_idx", 32'(gnt_idx), 32'd2);
        check("t1_rel_ptr", 32'(dbg_ptr), 32'd3);

        // 2. Round-robin fairness
        do_reset(1);
        exp_q = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                  4'b0000, 4'b1000, 4'b0000, 4'b0001};
        req  = 4'b1111;
        done = 1'b1;
        while (exp_q.size() > 0) begin
            logic [3:0] exp_gnt;
            step();
            exp_gnt = exp_q.pop_front();
            check("t2_rr_gnt", 32'(gnt), 32'(exp_gnt));
        end
        req  = 4'b0000;
        done = 1'b0;
        step();
        check("t2_end_ptr", 32'(dbg_ptr), 32'd1);

        // 3. Timeout with two contenders
        do_reset(1);
        req = 4'b0011;
        for (int owner = 0; owner < 2; owner++) begin
            step();
            for (int c = 0; c < MAX_HOLD; c++) begin
                check("t3_gnt", 32'(gnt), 32'(4'b0001 << owner));
                check("t3_hold", 32'(hold_cnt), 32'(c));
                if (c < MAX_HOLD - 1) step();
            end
            if (owner == 1) req = 4'b0000;
            step();
            check("t3_gap_gnt", 32'(gnt), 32'd0);
            check("t3_gap_valid", 32'(gnt_valid), 32'd0);
        end

        // 4. Withdrawal, then pointer wrap and skip (5)
        do_reset(1);
        req = 4'b1000;
        step();
        check("t4_gnt", 32'(gnt), 32'h8);
        step();
        step();
        check("t4_hold2", 32'(hold_cnt), 32'd2);
        req = 4'b0000;
        step();
        check("t4_valid", 32'(gnt_valid), 32'd0);
        check("t4_ptr", 32'(dbg_ptr), 32'd0);
        check("t4_idx", 32'(gnt_idx), 32'd3);
        repeat (2) begin
            step();
            check("t4_idle_gnt", 32'(gnt), 32'd0);
        end
        req = 4'b1010;
        step();
        check("t5_gnt", 32'(gnt), 32'h2);
        check("t5_idx", 32'(gnt_idx), 32'd1);
        req = 4'b0000;
        step();
        check("t5_ptr", 32'(dbg_ptr), 32'd2);

        // 6a. Reset mid-grant
        req = 4'b0100;
        step();
        check("t6_gnt", 32'(gnt), 32'h4);
        repeat (3) step();
        check("t6_hold3", 32'(hold_cnt), 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b0000;
        check_reset_outputs("t6_rst");

        // 6b. done on the timeout cycle gives one release
        step();
        req = 4'b0011;
        step();
        check("t6b_gnt", 32'(gnt), 32'h1);
        repeat (MAX_HOLD - 1) step();
        check("t6b_hold_last", 32'(hold_cnt), 32'(MAX_HOLD - 1));
        done = 1'b1;
        step();
        done = 1'b0;
        check("t6b_valid", 32'(gnt_valid), 32'd0);
        check("t6b_ptr", 32'(dbg_ptr), 32'd1);
        step();
        check("t6b_next_gnt", 32'(gnt), 32'h2);
        check("t6b_next_hold", 32'(hold_cnt), 32'd0);
        req = 4'b0000;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
